// File: rtl/xidoo_controller.sv
// xidoo_controller: Moore control FSM for the xidoo 8-bit accumulator CPU.
// Sequences fetch / decode / execute, handles the INPUT Enter handshake and HALT.
// MEM_LAT inserts read-wait states (FWAIT / DWAIT) before cycles that consume Instr.
// Optional build macro XIDOO_CTRL_STEP_EN adds a Step input for single-instruction
// stepping; without it the FSM is free-running.
module xidoo_controller #(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
`ifdef XIDOO_CTRL_STEP_EN
    input  logic       Step,
`endif
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       Halt,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        StStart  = 4'd0,
        StFwait  = 4'd1,
        StFetch  = 4'd2,
        StDecode = 4'd3,
        StDwait  = 4'd4,
        StLoad   = 4'd5,
        StStore  = 4'd6,
        StAdd    = 4'd7,
        StSub    = 4'd8,
        StInput  = 4'd9,
        StJz     = 4'd10,
        StJpos   = 4'd11,
        StHalt   = 4'd12
`ifdef XIDOO_CTRL_STEP_EN
        ,
        StStep   = 4'd13
`endif
    } state_e;

    // Execute state parked while DWAIT counts down
    typedef enum logic [1:0] {
        PendLoad = 2'd0,
        PendAdd  = 2'd1,
        PendSub  = 2'd2
    } pend_e;

    localparam bit          HasWait  = (MEM_LAT > 0);
    localparam int unsigned LatIdx   = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;
    localparam logic [2:0]  WaitLast = 3'(LatIdx);

    state_e     state_q, state_d;
    pend_e      pend_q, pend_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] enter_s_q;
    logic       enter_prev_q;
    logic       enter_rise;
    logic       go_fetch;

    assign enter_rise = enter_s_q[1] & ~enter_prev_q;

`ifdef XIDOO_CTRL_STEP_EN
    logic [1:0] step_s_q;
    logic       step_prev_q;
    logic       step_pend_q, step_pend_d;
    logic       step_rise;

    assign step_rise = step_s_q[1] & ~step_prev_q;
    // An edge seen early (e.g. during FWAIT) is remembered until FETCH consumes it
    assign go_fetch  = step_rise | step_pend_q;

    // Step pending flag: set by an edge, cleared when FETCH is entered
    always_comb begin
        step_pend_d = (step_pend_q | step_rise) & (state_d != StFetch);
    end

    // Step synchronizer, edge register and pending flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_s_q    <= 2'b00;
            step_prev_q <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            step_s_q    <= {step_s_q[0], Step};
            step_prev_q <= step_s_q[1];
            step_pend_q <= step_pend_d;
        end
    end
`else
    assign go_fetch = 1'b1;
`endif

    // Next-state, wait counter and pending-execute logic
    always_comb begin
        state_e fetch_next;
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = 3'd0;

        if (HasWait) begin
            fetch_next = StFwait;
        end else if (go_fetch) begin
            fetch_next = StFetch;
        end else begin
`ifdef XIDOO_CTRL_STEP_EN
            fetch_next = StStep;
`else
            fetch_next = StFetch;
`endif
        end

        case (state_q)
            StStart: begin
                if (HasWait) begin
                    state_d = StFwait;
                end else if (go_fetch) begin
                    state_d = StFetch;
                end
            end
            StFwait: begin
                if (cnt_q == WaitLast) begin
                    // Saturate so a stepped build can idle here at the end of the wait
                    cnt_d = cnt_q;
                    if (go_fetch) begin
                        state_d = StFetch;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                case (IR)
                    3'b000: begin
                        pend_d  = PendLoad;
                        state_d = HasWait ? StDwait : StLoad;
                    end
                    3'b001: state_d = StStore;
                    3'b010: begin
                        pend_d  = PendAdd;
                        state_d = HasWait ? StDwait : StAdd;
                    end
                    3'b011: begin
                        pend_d  = PendSub;
                        state_d = HasWait ? StDwait : StSub;
                    end
                    3'b100: state_d = StInput;
                    3'b101: state_d = StJz;
                    3'b110: state_d = StJpos;
                    3'b111: state_d = StHalt;
                    default: state_d = StStart;
                endcase
            end
            StDwait: begin
                if (cnt_q == WaitLast) begin
                    case (pend_q)
                        PendAdd: state_d = StAdd;
                        PendSub: state_d = StSub;
                        default: state_d = StLoad;
                    endcase
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StLoad, StStore, StAdd, StSub, StJz, StJpos: state_d = fetch_next;
            StInput: begin
                if (enter_rise) begin
                    state_d = fetch_next;
                end
            end
            StHalt: state_d = StHalt;
`ifdef XIDOO_CTRL_STEP_EN
            StStep: begin
                if (go_fetch) begin
                    state_d = StFetch;
                end
            end
`endif
            default: state_d = StStart;
        endcase
    end

    // State, counter, pending-execute and Enter synchronizer registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StStart;
            pend_q       <= PendLoad;
            cnt_q        <= 3'd0;
            enter_s_q    <= 2'b00;
            enter_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            enter_s_q    <= {enter_s_q[0], Enter};
            enter_prev_q <= enter_s_q[1];
        end
    end

    // Moore output decode from the state register (jump and INPUT load qualified by inputs)
    always_comb begin
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = 2'd0;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Halt    = 1'b0;
        case (state_q)
            StFetch: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            StDecode, StDwait: Meminst = 1'b1;
            StLoad: begin
                Meminst = 1'b1;
                Asel    = 2'd2;
                Aload   = 1'b1;
            end
            StStore: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            StAdd: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
            end
            StSub: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
                Sub     = 1'b1;
            end
            StInput: begin
                Asel  = 2'd1;
                Aload = enter_rise;
            end
            StJz: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            StJpos: begin
                // Zero is not positive
                JMPmux = 1'b1;
                PCload = Apos & ~Aeq0;
            end
            StHalt: Halt = 1'b1;
            default: ;
        endcase
    end

    assign State = state_q;

endmodule
